// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard resolver: FSM state encoding,
// request classes, the default bubble instruction and the request decoder.
package hazard_pkg;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FLUSH = 2'd1,
        REQ_STALL = 2'd2,
        REQ_HALT  = 2'd3
    } req_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Priority: halt > stall (any hazard) > flush > none.
    function automatic req_t req_decode(input logic halt_req,
                                        input logic hazard,
                                        input logic flush_req);
        if (halt_req)
            return REQ_HALT;
        else if (hazard)
            return REQ_STALL;
        else if (flush_req)
            return REQ_FLUSH;
        else
            return REQ_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr wins over inc and never wraps past all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Clear on reset or clr, otherwise count up until all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count_reg <= '0;
        else if (inc && (count_reg != '1))
            count_reg <= count_reg + 1'b1;
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_resolver.sv
// Turns ID-stage hazard/flush/halt requests into PC enable, IF/ID
// hold/flush and ID/EX bubble actions; owns the IF/ID register and keeps
// stall/flush statistics plus a stuck-stall watchdog.
module hazard_resolver
    import hazard_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter int          STALL_MAX = 8,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_pc,
    input  logic [31:0]      IF_instr,
    input  logic             branch_hazard,
    input  logic             load_use_hazard,
    input  logic             branch_flushD,
    input  logic             halt,
    input  logic             stat_clr,
    output logic             pc_we,
    output logic             flushE,
    output logic [31:0]      ID_pc,
    output logic [31:0]      ID_instr,
    output logic             ID_valid,
    output logic             halted,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int             WD_W   = $clog2(STALL_MAX + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_MAX);

    state_t          state_reg;
    req_t            req;
    logic [31:0]     id_pc_reg;
    logic [31:0]     id_instr_reg;
    logic            id_valid_reg;
    logic            halted_reg;
    logic            timeout_reg;
    logic [WD_W-1:0] consec_reg;

    // Effective request this cycle; the halted state behaves like a permanent halt.
    always_comb begin
        req = REQ_HALT;
        if (state_reg != S_HALTED)
            req = req_decode(halt, branch_hazard | load_use_hazard, branch_flushD);
    end

    // Zero-latency PC enable and ID/EX bubble, forced safe while in reset.
    always_comb begin
        pc_we  = 1'b0;
        flushE = 1'b1;
        if (rst_n && ((req == REQ_NONE) || (req == REQ_FLUSH))) begin
            pc_we  = 1'b1;
            flushE = 1'b0;
        end
    end

    // FSM, IF/ID register and watchdog, all with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_RUN;
            halted_reg   <= 1'b0;
            id_pc_reg    <= 32'h0;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
            consec_reg   <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            case (req)
                REQ_HALT: begin
                    state_reg  <= S_HALTED;
                    halted_reg <= 1'b1;
                    consec_reg <= '0;
                end
                REQ_STALL: begin
                    state_reg <= S_STALL;
                    if (consec_reg != WD_MAX)
                        consec_reg <= consec_reg + 1'b1;
                    if (consec_reg == WD_MAX - 1'b1)
                        timeout_reg <= 1'b1;
                end
                REQ_FLUSH: begin
                    state_reg    <= S_RUN;
                    consec_reg   <= '0;
                    id_pc_reg    <= IF_pc;
                    id_instr_reg <= NOP_INSTR;
                    id_valid_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= S_RUN;
                    consec_reg   <= '0;
                    id_pc_reg    <= IF_pc;
                    id_instr_reg <= IF_instr;
                    id_valid_reg <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (req == REQ_STALL),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (req == REQ_FLUSH),
        .count (flush_cnt)
    );

    assign ID_pc         = id_pc_reg;
    assign ID_instr      = id_instr_reg;
    assign ID_valid      = id_valid_reg;
    assign halted        = halted_reg;
    assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_hazard_resolver.sv
// Directed bench for hazard_resolver with hand-computed expectations.
module tb_hazard_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_pc;
    logic [31:0] IF_instr;
    logic        branch_hazard;
    logic        load_use_hazard;
    logic        branch_flushD;
    logic        halt;
    logic        stat_clr;
    logic        pc_we;
    logic        flushE;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;
    logic        halted;
    logic        stall_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_resolver #(.CNT_W(16), .STALL_MAX(8), .NOP_INSTR(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_pc           (IF_pc),
        .IF_instr        (IF_instr),
        .branch_hazard   (branch_hazard),
        .load_use_hazard (load_use_hazard),
        .branch_flushD   (branch_flushD),
        .halt            (halt),
        .stat_clr        (stat_clr),
        .pc_we           (pc_we),
        .flushE          (flushE),
        .ID_pc           (ID_pc),
        .ID_instr        (ID_instr),
        .ID_valid        (ID_valid),
        .halted          (halted),
        .stall_timeout   (stall_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    // Advance one clock edge, land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag, input logic exp_pc_we, input logic exp_flushE);
        #1;
        check({tag, ".pc_we"}, {31'b0, pc_we}, {31'b0, exp_pc_we});
        check({tag, ".flushE"}, {31'b0, flushE}, {31'b0, exp_flushE});
    endtask

    initial begin
        rst_n = 1'b0; IF_pc = 32'h0040_0000; IF_instr = 32'h2008_0005;
        branch_hazard = 0; load_use_hazard = 0; branch_flushD = 0; halt = 0; stat_clr = 0;
        step(); step();

        // Reset state
        check_comb("rst", 1'b0, 1'b1);
        check("rst.ID_pc", ID_pc, 32'h0);
        check("rst.ID_instr", ID_instr, 32'h0);
        check("rst.ID_valid", {31'b0, ID_valid}, 32'd0);
        check("rst.halted", {31'b0, halted}, 32'd0);
        check("rst.timeout", {31'b0, stall_timeout}, 32'd0);
        check("rst.stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("rst.flush_cnt", {16'b0, flush_cnt}, 32'd0);

        // Free run
        rst_n = 1'b1;
        check_comb("run", 1'b1, 1'b0);
        step();
        check("run.ID_pc", ID_pc, 32'h0040_0000);
        check("run.ID_instr", ID_instr, 32'h2008_0005);
        check("run.ID_valid", {31'b0, ID_valid}, 32'd1);

        // Two-cycle branch hazard
        IF_pc = 32'h0040_0004; IF_instr = 32'h8c09_0000; branch_hazard = 1;
        check_comb("bh1", 1'b0, 1'b1);
        step();
        check("bh1.ID_pc", ID_pc, 32'h0040_0000);
        check_comb("bh2", 1'b0, 1'b1);
        step();
        branch_hazard = 0;
        check_comb("bh_end", 1'b1, 1'b0);
        check("bh.ID_pc_hold", ID_pc, 32'h0040_0000);
        check("bh.ID_instr_hold", ID_instr, 32'h2008_0005);
        check("bh.stall_cnt", {16'b0, stall_cnt}, 32'd2);
        step();
        check("bh.ID_pc_resume", ID_pc, 32'h0040_0004);
        check("bh.ID_instr_resume", ID_instr, 32'h8c09_0000);

        // Branch flush
        IF_pc = 32'h0040_0010; IF_instr = 32'h1234_5678; branch_flushD = 1;
        check_comb("fl", 1'b1, 1'b0);
        step();
        branch_flushD = 0;
        check("fl.ID_pc", ID_pc, 32'h0040_0010);
        check("fl.ID_instr", ID_instr, 32'h0);
        check("fl.ID_valid", {31'b0, ID_valid}, 32'd0);
        check("fl.flush_cnt", {16'b0, flush_cnt}, 32'd1);

        // Clear statistics, then hazard+flush followed by flush alone
        stat_clr = 1; IF_pc = 32'h0040_0014; IF_instr = 32'h0000_0020;
        step();
        stat_clr = 0;
        check("clr.stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("clr.flush_cnt", {16'b0, flush_cnt}, 32'd0);
        IF_pc = 32'h0040_0020; IF_instr = 32'h2108_0001;
        branch_hazard = 1; branch_flushD = 1;
        check_comb("hf1", 1'b0, 1'b1);
        step();
        branch_hazard = 0;
        check("hf1.flush_cnt", {16'b0, flush_cnt}, 32'd0);
        check("hf1.stall_cnt", {16'b0, stall_cnt}, 32'd1);
        check("hf1.ID_pc", ID_pc, 32'h0040_0014);
        check_comb("hf2", 1'b1, 1'b0);
        step();
        branch_flushD = 0;
        check("hf2.ID_pc", ID_pc, 32'h0040_0020);
        check("hf2.ID_valid", {31'b0, ID_valid}, 32'd0);
        check("hf2.stall_cnt", {16'b0, stall_cnt}, 32'd1);
        check("hf2.flush_cnt", {16'b0, flush_cnt}, 32'd1);

        // Load-use held for 9 cycles: watchdog at the 8th edge
        load_use_hazard = 1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("wd.timeout_%0d", i), {31'b0, stall_timeout}, (i >= 8) ? 32'd1 : 32'd0);
        end
        check("wd.stall_cnt", {16'b0, stall_cnt}, 32'd10);
        load_use_hazard = 0; IF_pc = 32'h0040_0030; IF_instr = 32'hAABB_CCDD;
        step();
        check("wd.sticky", {31'b0, stall_timeout}, 32'd1);
        check("wd.ID_pc", ID_pc, 32'h0040_0030);
        stat_clr = 1; load_use_hazard = 1;
        step();
        stat_clr = 0; load_use_hazard = 0;
        check("clrhz.stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("clrhz.flush_cnt", {16'b0, flush_cnt}, 32'd0);
        step();

        // Halt with simultaneous flush
        halt = 1; branch_flushD = 1; IF_pc = 32'h0040_0040;
        check_comb("halt", 1'b0, 1'b1);
        step();
        halt = 0; branch_flushD = 0;
        check("halt.halted", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_comb($sformatf("halted_%0d", i), 1'b0, 1'b1);
            step();
            check($sformatf("halted_%0d.flush_cnt", i), {16'b0, flush_cnt}, 32'd0);
            check($sformatf("halted_%0d.ID_pc", i), ID_pc, 32'h0040_0030);
        end

        // One-cycle reset leaves HALTED
        rst_n = 0;
        check_comb("rst2", 1'b0, 1'b1);
        step();
        rst_n = 1;
        check("rst2.halted", {31'b0, halted}, 32'd0);
        check("rst2.ID_pc", ID_pc, 32'h0);
        check("rst2.ID_instr", ID_instr, 32'h0);
        check("rst2.ID_valid", {31'b0, ID_valid}, 32'd0);
        check("rst2.timeout", {31'b0, stall_timeout}, 32'd0);
        check("rst2.stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("rst2.flush_cnt", {16'b0, flush_cnt}, 32'd0);
        check_comb("rst2.run", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_resolver.md
Name: hazard_resolver

Overview:
- Consumer end of the hazard-detection interface in the 5-stage MIPS pipeline.
- Takes branch-hazard, load-use-hazard, branch-flush and halt requests from the ID-stage detectors and turns them into concrete pipeline actions:
  - PC write-enable
  - IF/ID pipeline register hold/flush (the register is owned by this block)
  - ID/EX bubble insertion
- Also keeps saturating stall/flush statistics and a stuck-stall watchdog.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt statistic counters.
- STALL_MAX, 8, number of consecutive stall cycles after which stall_timeout latches.
- NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on flush or reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- IF_pc  in  32  PC of the instruction currently in IF.
- IF_instr  in  32  instruction word fetched in IF.
- branch_hazard  in  1  ID branch needs an operand still in EX (regwe) or MEM (load).
- load_use_hazard  in  1  ID instruction depends on a load in EX.
- branch_flushD  in  1  ID holds a taken j/jal/jr/branch; the IF instruction is wrong-path.
- halt  in  1  syscall/halt decoded in ID.
- stat_clr  in  1  synchronous clear of both statistic counters.
- pc_we  out  1  PC register write enable (combinational).
- flushE  out  1  load a bubble into ID/EX at the next edge (combinational).
- ID_pc  out  32  IF/ID register: PC.
- ID_instr  out  32  IF/ID register: instruction.
- ID_valid  out  1  IF/ID register: the entry is a real instruction.
- halted  out  1  high while in the HALTED state.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of IF/ID flushes.

Behaviour:
- Reset (rst_n low at a rising edge):
  - ID_pc=0, ID_instr=NOP_INSTR, ID_valid=0.
  - state=RUN, consecutive-stall counter=0.
  - stall_timeout=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs while rst_n is low: pc_we=0, flushE=1.
  - A reset mid-stall or mid-halt abandons that state immediately.
- Request priority, evaluated every cycle: halt > hazard (branch_hazard OR load_use_hazard) > branch_flushD > none.
- FSM states: RUN, STALL, HALTED.
  - RUN:
    - hazard -> STALL.
    - halt -> HALTED.
    - otherwise stay in RUN.
  - STALL:
    - hazard still high -> stay in STALL.
    - hazard low -> RUN.
    - halt -> HALTED.
  - HALTED:
    - Absorbing; only reset leaves it.
- Actions per cycle. pc_we and flushE are decoded from the request, not from the state, so they act in the same cycle:
  - halt, or state=HALTED:
    - pc_we=0, flushE=1, IF/ID holds.
    - No counter increments.
  - hazard:
    - pc_we=0, flushE=1, IF/ID holds its contents.
    - stall_cnt +1.
    - A simultaneous branch_flushD is ignored; the branch re-evaluates after the stall.
  - branch_flushD only:
    - pc_we=1, flushE=0.
    - IF/ID loads ID_pc=IF_pc, ID_instr=NOP_INSTR, ID_valid=0.
    - flush_cnt +1.
  - none:
    - pc_we=1, flushE=0.
    - IF/ID loads IF_pc/IF_instr with ID_valid=1.
- Watchdog:
  - The consecutive-stall counter increments on each hazard cycle and clears on any non-hazard cycle.
  - When it reaches STALL_MAX, stall_timeout sets at that edge and stays set until reset.
  - The counter saturates at STALL_MAX.
- Statistic counters:
  - Saturate at all-ones; they never wrap.
  - stat_clr has priority over increment: the counter becomes 0 that edge, even if an increment was due.
- Latency:
  - IF/ID update is visible one cycle after the request.
  - pc_we/flushE respond with zero cycles of latency.

Decomposition:
- Shared package hazard_pkg:
  - State encoding constants S_RUN=2'd0, S_STALL=2'd1, S_HALTED=2'd2.
  - NOP_INSTR default.
  - A request-priority function returning {halt, stall, flush, none}.
- One sub-module: sat_counter, parameterised by width, with inc and clr inputs (clr priority). Instantiated twice, for stall_cnt and flush_cnt.
- FSM, IF/ID register and watchdog live in hazard_resolver.

Test Plan:
- Reset then free run:
  - Stimulus: IF_pc=0x0040_0000, IF_instr=0x2008_0005, no requests.
  - Response: after one edge ID_pc=0x0040_0000, ID_instr=0x2008_0005, ID_valid=1; pc_we=1, flushE=0.
- 2-cycle branch_hazard:
  - Stimulus: branch_hazard high for 2 cycles.
  - Response: pc_we=0 and flushE=1 for exactly 2 cycles; IF/ID unchanged; stall_cnt=2; state returns to RUN.
- branch_flushD with IF_pc=0x0040_0010:
  - Response: ID_pc=0x0040_0010, ID_instr=0x0, ID_valid=0; flush_cnt=1; pc_we=1.
- branch_hazard and branch_flushD together for 1 cycle, then branch_flushD alone:
  - Response: first cycle stalls with flush_cnt unchanged; second cycle flushes; final stall_cnt=1, flush_cnt=1.
- load_use_hazard held for 9 cycles with STALL_MAX=8:
  - Response: stall_timeout rises at the 8th stall edge and stays 1 after the hazard drops.
  - Then stat_clr together with a hazard -> stall_cnt=0.
- halt together with branch_flushD:
  - Response: halted=1; pc_we=0, flushE=1 forever; flush_cnt unchanged.
  - A 1-cycle rst_n=0 returns to RUN with all outputs at their reset values.
